// File: rtl/axi_lite_downsize_ctrl_pkg.sv
// Shared definitions for the 64-to-32-bit request downsizer: FSM state
// encodings, the upper-beat address offset and the strobe used for read beats.
package axi_lite_downsize_ctrl_pkg;

    // 3-bit state encoding; IDLE is all-zero so the debug state reads 0 in reset.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO_REQ  = 3'd1,
        ST_LO_WAIT = 3'd2,
        ST_HI_REQ  = 3'd3,
        ST_HI_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Byte offsets of the two beats inside the 8-byte aligned window.
    localparam logic [2:0] LO_OFFSET = 3'd0;
    localparam logic [2:0] HI_OFFSET = 3'd4;

    // Reads always fetch the whole 32-bit word.
    localparam logic [3:0] READ_STRB = 4'hF;

    // Strobe presented on a beat: the request's half-strobe for writes, full word for reads.
    function automatic logic [3:0] beat_strb(input logic we, input logic [3:0] half_strb);
        return we ? half_strb : READ_STRB;
    endfunction

endpackage

// File: rtl/downsize_watchdog.sv
// Per-beat wait-state watchdog for the downsizer. Compiled only when
// DOWNSIZE_TIMEOUT_EN is defined. The count restarts on i_clear, advances on
// each enabled cycle, and o_expired flags the LIMIT-th enabled cycle.
`ifdef DOWNSIZE_TIMEOUT_EN
module downsize_watchdog
    import axi_lite_downsize_ctrl_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_count;

    assign o_expired = i_enable && (r_count == CW'(LIMIT - 1));

    // Cycle counter: restart on state entry, hold once expired.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/axi_lite_downsize_ctrl.sv
// Sequencer carrying one 64-bit request at a time onto a 32-bit slave bus.
// Writes issue 0-2 beats depending on which strobe halves are set; reads
// always issue two beats and merge the data into 64 bits {hi,lo}.
// Optional per-beat timeout: define DOWNSIZE_TIMEOUT_EN.
//
// Handshakes: a transfer happens on the rising clock edge where valid and
// ready are both high; once raised, valid and its payload hold until that
// edge. The m_rsp_valid return channel is a single-cycle pulse with no ready.
module axi_lite_downsize_ctrl
    import axi_lite_downsize_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_rsp_valid,
    input  logic [31:0]       m_rsp_rdata,
    input  logic              m_rsp_err,
    output logic [2:0]        dbg_state
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-4:0] r_base;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wstrb;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_need_hi;
    logic              w_expired;
    logic              w_timeout_fire;
    logic              w_unused_addr_lsbs;

    // Low address bits are ignored: every request is treated as 8-byte aligned.
    assign w_unused_addr_lsbs = ^req_addr[2:0];

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_need_hi = !r_we || (r_wstrb[7:4] != 4'h0);
    assign dbg_state = r_state;

`ifdef DOWNSIZE_TIMEOUT_EN
    logic w_state_change;
    logic w_in_beat;

    assign w_state_change = (w_next != r_state);
    assign w_in_beat      = (r_state == ST_LO_REQ) || (r_state == ST_LO_WAIT) ||
                            (r_state == ST_HI_REQ) || (r_state == ST_HI_WAIT);

    downsize_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_clear  (w_state_change),
        .i_enable (w_in_beat),
        .o_expired(w_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a handshake or beat response always beats the timeout.
    always_comb begin
        w_next         = r_state;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!req_we || (req_wstrb[3:0] != 4'h0)) begin
                        w_next = ST_LO_REQ;
                    end else if (req_wstrb[7:4] != 4'h0) begin
                        w_next = ST_HI_REQ;
                    end else begin
                        w_next = ST_RESP;
                    end
                end
            end
            ST_LO_REQ: begin
                if (m_ready) begin
                    w_next = ST_LO_WAIT;
                end else if (w_expired) begin
                    w_next         = ST_RESP;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_LO_WAIT: begin
                if (m_rsp_valid) begin
                    w_next = w_need_hi ? ST_HI_REQ : ST_RESP;
                end else if (w_expired) begin
                    w_next         = ST_RESP;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_HI_REQ: begin
                if (m_ready) begin
                    w_next = ST_HI_WAIT;
                end else if (w_expired) begin
                    w_next         = ST_RESP;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_HI_WAIT: begin
                if (m_rsp_valid || w_expired) begin
                    w_next         = ST_RESP;
                    w_timeout_fire = !m_rsp_valid;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, read-data merge and error accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_base  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_base  <= req_addr[ADDR_W-1:3];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if ((r_state == ST_LO_WAIT) && m_rsp_valid) begin
                if (!r_we) begin
                    r_rdata[31:0] <= m_rsp_rdata;
                end
                r_err <= r_err | m_rsp_err;
            end
            if ((r_state == ST_HI_WAIT) && m_rsp_valid) begin
                if (!r_we) begin
                    r_rdata[63:32] <= m_rsp_rdata;
                end
                r_err <= r_err | m_rsp_err;
            end
            if (w_timeout_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Beat mux and response outputs; everything is zero outside its state.
    always_comb begin
        m_valid   = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (r_state)
            ST_LO_REQ: begin
                m_valid = 1'b1;
                m_we    = r_we;
                m_addr  = {r_base, LO_OFFSET};
                m_wdata = r_wdata[31:0];
                m_wstrb = beat_strb(r_we, r_wstrb[3:0]);
            end
            ST_HI_REQ: begin
                m_valid = 1'b1;
                m_we    = r_we;
                m_addr  = {r_base, HI_OFFSET};
                m_wdata = r_wdata[63:32];
                m_wstrb = beat_strb(r_we, r_wstrb[7:4]);
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = r_rdata;
                rsp_err   = r_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_downsize_ctrl.sv
// Self-checking bench for axi_lite_downsize_ctrl: a 32-bit slave model,
// a negedge monitor popping expected beats/responses, and directed plus
// random request sequences. Timeout scenario runs when DOWNSIZE_TIMEOUT_EN is defined.
module tb_axi_lite_downsize_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic        m_valid, m_ready, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    logic [2:0]  dbg_state;

    axi_lite_downsize_ctrl #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err  (m_rsp_err),
        .dbg_state  (dbg_state)
    );

    // Scoreboard queues: beat = {we, addr, wdata, strb}; response = {err, rdata}.
    logic [68:0] exp_beat_q[$];
    logic [64:0] exp_rsp_q[$];
    logic [32:0] slv_rsp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int rsp_rise_cyc = 0;
    int hs_cyc = 0;

    bit slv_random = 0;
    bit slv_stall = 0;
    bit slv_mute = 0;
    int inject_req = 0;
    int inject_ack = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    bit slv_due = 0;
    int slv_delay = 0;
    initial begin
        m_ready = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_err = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                slv_due = 0;
            end else if (m_valid && m_ready) begin
                slv_due = 1;
                slv_delay = slv_random ? $urandom_range(0, 2) : 0;
            end
            @(posedge clock);
            #1;
            m_rsp_valid = 1'b0;
            m_rsp_rdata = '0;
            m_rsp_err = 1'b0;
            if (inject_req != inject_ack) begin
                inject_ack = inject_req;
                m_rsp_valid = 1'b1;
                m_rsp_rdata = 32'hDEAD_BEEF;
                m_rsp_err = 1'b1;
            end else if (slv_due) begin
                if (slv_delay > 0) begin
                    slv_delay--;
                end else begin
                    slv_due = 0;
                    if (!slv_mute) begin
                        m_rsp_valid = 1'b1;
                        if (slv_rsp_q.size() > 0) begin
                            {m_rsp_err, m_rsp_rdata} = slv_rsp_q.pop_front();
                        end else begin
                            m_rsp_rdata = $urandom();
                        end
                    end
                end
            end
            m_ready = !slv_stall && (!slv_random || ($urandom_range(0, 2) != 0));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic rsp_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            rsp_prev = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                hs_cyc = cyc;
                if (exp_beat_q.size() == 0) begin
                    check_val("beat_extra", 128'(exp_beat_q.size()), 128'(1));
                end else begin
                    check_val("beat", 128'({m_we, m_addr, m_wdata, m_wstrb}), 128'(exp_beat_q.pop_front()));
                end
            end
            if (rsp_valid && !rsp_prev) begin
                rsp_rise_cyc = cyc;
            end
            rsp_prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    check_val("rsp_extra", 128'(exp_rsp_q.size()), 128'(1));
                end else begin
                    check_val("rsp", 128'({rsp_err, rsp_rdata}), 128'(exp_rsp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wstrb);
        int n;
        bit done;
        n = 0;
        done = 0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        while (!done && n < 50) begin
            @(negedge clock);
            if (req_ready) begin
                done = 1;
                accept_cyc = cyc;
            end
            @(posedge clock);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!done) check_val("req_accept", 128'(done), 128'(1));
    endtask

    // Model: which beats a request produces and the merged response it earns.
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wstrb, input logic [32:0] lo_rsp, input logic [32:0] hi_rsp);
        logic [31:0] base;
        logic        err;
        logic [63:0] rd;
        base = {addr[31:3], 3'b000};
        err = 1'b0;
        rd = '0;
        if (!we || (wstrb[3:0] != 4'h0)) begin
            exp_beat_q.push_back({we, base, wdata[31:0], we ? wstrb[3:0] : 4'hF});
            slv_rsp_q.push_back(lo_rsp);
            err = err | lo_rsp[32];
            if (!we) rd[31:0] = lo_rsp[31:0];
        end
        if (!we || (wstrb[7:4] != 4'h0)) begin
            exp_beat_q.push_back({we, base + 32'd4, wdata[63:32], we ? wstrb[7:4] : 4'hF});
            slv_rsp_q.push_back(hi_rsp);
            err = err | hi_rsp[32];
            if (!we) rd[63:32] = hi_rsp[31:0];
        end
        exp_rsp_q.push_back({err, rd});
        drive_req(we, addr, wdata, wstrb);
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_rsp_q.size() != 0) begin
            check_val("rsp_timeout", 128'(exp_rsp_q.size()), 128'(0));
            exp_rsp_q.delete();
        end
        check_val("beats_drained", 128'(exp_beat_q.size()), 128'(0));
        exp_beat_q.delete();
        slv_rsp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        rw;
        logic [7:0]  rs;
        logic [3:0]  r4;
        int          n;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clock);
        check_val("rst_req_ready", 128'(req_ready), 128'(0));
        check_val("rst_beat_outs", 128'({m_valid, m_we, m_addr, m_wdata, m_wstrb}), 128'(0));
        check_val("rst_rsp_outs", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("idle_req_ready", 128'(req_ready), 128'(1));
        check_val("idle_state", 128'(dbg_state), 128'(0));
        @(posedge clock);
        #1;

        // 1: two-beat read, zero-wait slave, minimum latency.
        send_req(1'b0, 32'h0000_1004, 64'h0123_4567_89AB_CDEF, 8'h00,
                 {1'b0, 32'hAAAA_0001}, {1'b0, 32'hBBBB_0002});
        wait_rsp(40);
        check_val("rd_latency", 128'(rsp_rise_cyc - accept_cyc), 128'(5));

        // 2: upper-half-only write.
        send_req(1'b1, 32'h0000_2008, 64'h1122_3344_5566_7788, 8'hF0, 33'h0, 33'h0);
        wait_rsp(40);

        // 3: lower-half-only write, then a zero-strobe write.
        send_req(1'b1, 32'h0000_2010, 64'h1122_3344_5566_7788, 8'h0F, 33'h0, 33'h0);
        wait_rsp(40);
        send_req(1'b1, 32'h0000_2018, 64'h1122_3344_5566_7788, 8'h00, 33'h0, 33'h0);
        wait_rsp(40);
        check_val("zero_strb_latency", 128'(rsp_rise_cyc - accept_cyc), 128'(1));

        // 4: error on the lower beat, response held under backpressure.
        rsp_ready = 1'b0;
        send_req(1'b1, 32'h0000_2020, 64'hFEED_FACE_0BAD_CAFE, 8'hFF,
                 {1'b1, 32'h0}, {1'b0, 32'h0});
        n = 0;
        @(negedge clock);
        while (!rsp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_val("rsp_hold", 128'({rsp_valid, rsp_err, rsp_rdata}), 128'({1'b1, 1'b1, 64'h0}));
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        wait_rsp(40);

        // 5: stalled beat holds its fields; reset mid-wait; late response ignored.
        slv_stall = 1;
        slv_mute = 1;
        exp_beat_q.push_back({1'b0, 32'h0000_3000, 32'hCAFE_0123, 4'hF});
        drive_req(1'b0, 32'h0000_3003, 64'h0BAD_F00D_CAFE_0123, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("stall_beat", 128'({m_valid, m_we, m_addr, m_wdata, m_wstrb}),
                      128'({1'b1, 1'b0, 32'h0000_3000, 32'hCAFE_0123, 4'hF}));
        end
        @(posedge clock);
        #1;
        slv_stall = 0;
        n = 0;
        while (exp_beat_q.size() != 0 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_val("stall_release", 128'(exp_beat_q.size()), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_val("midrst_req_ready", 128'(req_ready), 128'(0));
        check_val("midrst_outs", 128'({m_valid, m_we, m_addr, m_wdata, m_wstrb, rsp_valid, rsp_err}), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_beat_q.delete();
        exp_rsp_q.delete();
        slv_rsp_q.delete();
        inject_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_val("post_rst_idle", 128'({dbg_state, req_ready, m_valid, rsp_valid, rsp_rdata}),
                      128'({3'd0, 1'b1, 1'b0, 1'b0, 64'h0}));
        end
        @(posedge clock);
        #1;
        slv_mute = 0;

`ifdef DOWNSIZE_TIMEOUT_EN
        // 6: slave never answers; timeout 16 cycles after entering the wait state.
        slv_mute = 1;
        exp_beat_q.push_back({1'b0, 32'h0000_4000, 32'h0, 4'hF});
        exp_rsp_q.push_back({1'b1, 64'h0});
        drive_req(1'b0, 32'h0000_4000, 64'h0, 8'h00);
        wait_rsp(80);
        check_val("timeout_latency", 128'(rsp_rise_cyc - (hs_cyc + 1)), 128'(16));
        slv_mute = 0;
`endif

        // Random mix with wait states, delayed responses and errors.
        slv_random = 1;
        for (int i = 0; i < 30; i++) begin
            rw = 1'($urandom_range(0, 1));
            r4 = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: rs = 8'h00;
                1: rs = {4'h0, r4};
                2: rs = {r4, 4'h0};
                default: rs = 8'($urandom_range(0, 255));
            endcase
            send_req(rw, $urandom(), {$urandom(), $urandom()}, rs,
                     {($urandom_range(0, 3) == 0), $urandom()},
                     {($urandom_range(0, 3) == 0), $urandom()});
            wait_rsp(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
